// File: rtl/axi4_burst_mem_responder.sv
// AXI4 INCR burst responder backed by a word-addressed RAM.
// One outstanding read and one outstanding write, running concurrently.
module axi4_burst_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      i_ar_valid,
    output logic                      o_ar_ready,
    input  logic [ADDR_WIDTH-1:0]     i_ar_addr,
    input  logic [7:0]                i_ar_len,
    output logic                      o_r_valid,
    input  logic                      i_r_ready,
    output logic [DATA_WIDTH-1:0]     o_r_data,
    output logic                      o_r_last,
    output logic [1:0]                o_r_resp,
    input  logic                      i_aw_valid,
    output logic                      o_aw_ready,
    input  logic [ADDR_WIDTH-1:0]     i_aw_addr,
    input  logic [7:0]                i_aw_len,
    input  logic                      i_w_valid,
    output logic                      o_w_ready,
    input  logic [DATA_WIDTH-1:0]     i_w_data,
    input  logic [DATA_WIDTH/8-1:0]   i_w_strb,
    input  logic                      i_w_last,
    output logic                      o_b_valid,
    input  logic                      i_b_ready,
    output logic [1:0]                o_b_resp
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF + 1;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(MEM_DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    r_state_t              r_state_q, r_state_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [8:0]            r_cnt_q, r_cnt_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_last_q, r_last_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [IDX_W-1:0]      rd_idx;
    logic                  r_load;

    w_state_t              w_state_q, w_state_d;
    logic [IDX_W-1:0]      w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [8:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  mem_we;
    logic                  beat_ok;

    generate
        if (OFF > 0) begin : g_unused
            logic unused_lsb;
            assign unused_lsb = ^{i_ar_addr[OFF-1:0], i_aw_addr[OFF-1:0]};
        end
    endgenerate

    // Read data is captured into the output register at the presenting
    // edge, so a same-edge write to that word is not seen by this beat.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        rd_idx    = r_idx_q;
        r_load    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (i_ar_valid) begin
                    r_idx_d   = {1'b0, i_ar_addr[ADDR_WIDTH-1:OFF]};
                    r_len_d   = i_ar_len;
                    r_cnt_d   = '0;
                    r_valid_d = 1'b1;
                    r_last_d  = (i_ar_len == 8'd0);
                    r_state_d = R_DATA;
                    rd_idx    = r_idx_d;
                    r_load    = 1'b1;
                end
            end
            R_DATA: begin
                if (i_r_ready) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d  = r_idx_q + 1'b1;
                        r_cnt_d  = r_cnt_q + 9'd1;
                        r_last_d = (r_cnt_d == {1'b0, r_len_q});
                        rd_idx   = r_idx_d;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            if (rd_idx < DEPTH_I) begin
                r_data_d = mem[rd_idx[MEM_AW-1:0]];
                r_resp_d = OKAY;
            end else begin
                r_data_d = '0;
                r_resp_d = SLVERR;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        beat_ok   = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (i_aw_valid) begin
                    w_idx_d   = {1'b0, i_aw_addr[ADDR_WIDTH-1:OFF]};
                    w_len_d   = i_aw_len;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (i_w_valid) begin
                    beat_ok = (w_cnt_q <= {1'b0, w_len_q})
                            && (w_idx_q < DEPTH_I);
                    mem_we  = beat_ok;
                    if (!beat_ok
                        || (i_w_last != (w_cnt_q == {1'b0, w_len_q})))
                        w_err_d = 1'b1;
                    w_idx_d = w_idx_q + 1'b1;
                    // Saturate so overlong bursts never wrap back in range.
                    if (w_cnt_q != 9'h1ff)
                        w_cnt_d = w_cnt_q + 9'd1;
                    if (i_w_last)
                        w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (i_b_ready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && arstn) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_w_strb[b])
                    mem[w_idx_q[MEM_AW-1:0]][8*b +: 8] <= i_w_data[8*b +: 8];
            end
        end
    end

    assign o_ar_ready = (r_state_q == R_IDLE);
    assign o_r_valid  = r_valid_q;
    assign o_r_data   = r_data_q;
    assign o_r_last   = r_last_q;
    assign o_r_resp   = r_resp_q;
    assign o_aw_ready = (w_state_q == W_IDLE);
    assign o_w_ready  = (w_state_q == W_DATA);
    assign o_b_valid  = (w_state_q == W_RESP);
    assign o_b_resp   = w_err_q ? SLVERR : OKAY;

endmodule

// File: tb/tb_axi4_burst_mem_responder.sv
// Directed and randomized bench for axi4_burst_mem_responder with a
// word-array reference model of the RAM.
module tb_axi4_burst_mem_responder;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_ar_valid, o_ar_ready;
    logic [31:0] i_ar_addr;
    logic [7:0]  i_ar_len;
    logic        o_r_valid, i_r_ready;
    logic [31:0] o_r_data;
    logic        o_r_last;
    logic [1:0]  o_r_resp;
    logic        i_aw_valid, o_aw_ready;
    logic [31:0] i_aw_addr;
    logic [7:0]  i_aw_len;
    logic        i_w_valid, o_w_ready;
    logic [31:0] i_w_data;
    logic [3:0]  i_w_strb;
    logic        i_w_last;
    logic        o_b_valid, i_b_ready;
    logic [1:0]  o_b_resp;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];
    bit          known [DEPTH];

    always #5 clk = ~clk;

    axi4_burst_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arstn(arstn),
        .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready),
        .i_ar_addr(i_ar_addr), .i_ar_len(i_ar_len),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready),
        .o_r_data(o_r_data), .o_r_last(o_r_last), .o_r_resp(o_r_resp),
        .i_aw_valid(i_aw_valid), .o_aw_ready(o_aw_ready),
        .i_aw_addr(i_aw_addr), .i_aw_len(i_aw_len),
        .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
        .i_w_data(i_w_data), .i_w_strb(i_w_strb), .i_w_last(i_w_last),
        .o_b_valid(o_b_valid), .i_b_ready(i_b_ready), .o_b_resp(o_b_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: a beat lands if its count <= len and its word is in range;
    // any dropped beat or misplaced w_last makes the response SLVERR.
    task automatic wr(input int unsigned addr, input int len,
                      input logic [31:0] dq[$], input logic [3:0] sq[$],
                      output logic [1:0] resp);
        int n, base, nb, idx;
        bit err;
        logic [31:0] w, d;
        logic [3:0] s;
        base = int'(addr >> 2);
        nb = dq.size();
        err = (nb - 1 != len);
        @(negedge clk);
        i_aw_valid = 1'b1; i_aw_addr = addr; i_aw_len = 8'(len);
        n = 0;
        while (!o_aw_ready && n < 100) begin @(negedge clk); n++; end
        chk("aw_ready", 32'(o_aw_ready), 32'd1);
        @(posedge clk); #1 i_aw_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            d = dq[b]; s = sq[b];
            i_w_valid = 1'b1; i_w_data = d; i_w_strb = s;
            i_w_last = (b == nb - 1);
            n = 0;
            while (!o_w_ready && n < 100) begin @(negedge clk); n++; end
            chk("w_ready", 32'(o_w_ready), 32'd1);
            @(posedge clk);
            idx = base + b;
            if (b <= len && idx < DEPTH) begin
                w = mdl[idx];
                for (int k = 0; k < 4; k++)
                    if (s[k]) w[8*k +: 8] = d[8*k +: 8];
                mdl[idx] = w;
                if (s == 4'hf) known[idx] = 1'b1;
            end else begin
                err = 1'b1;
            end
            #1 i_w_valid = 1'b0; i_w_last = 1'b0;
        end
        @(negedge clk);
        i_b_ready = 1'b1;
        n = 0;
        while (!o_b_valid && n < 100) begin @(negedge clk); n++; end
        chk("b_valid", 32'(o_b_valid), 32'd1);
        resp = o_b_resp;
        chk("b_resp", 32'(o_b_resp), err ? 32'd2 : 32'd0);
        @(posedge clk); #1 i_b_ready = 1'b0;
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0,..., 2: random ready
    task automatic rd(input int unsigned addr, input int len, input int mode);
        int n, beat, cyc, base, idx;
        logic rdy;
        base = int'(addr >> 2);
        @(negedge clk);
        i_ar_valid = 1'b1; i_ar_addr = addr; i_ar_len = 8'(len);
        n = 0;
        while (!o_ar_ready && n < 100) begin @(negedge clk); n++; end
        chk("ar_ready", 32'(o_ar_ready), 32'd1);
        chk("r_pre", 32'(o_r_valid), 32'd0);
        @(posedge clk); #1 i_ar_valid = 1'b0;
        chk("r_first", 32'(o_r_valid), 32'd1);
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 3000) begin
            @(negedge clk);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 0);
            else rdy = 1'($urandom_range(0, 1));
            i_r_ready = rdy;
            cyc++;
            idx = base + beat;
            chk("r_valid", 32'(o_r_valid), 32'd1);
            chk("ar_busy", 32'(o_ar_ready), 32'd0);
            chk("r_last", 32'(o_r_last), 32'(beat == len));
            if (idx < DEPTH) begin
                if (known[idx]) chk("r_data", o_r_data, mdl[idx]);
                chk("r_resp", 32'(o_r_resp), 32'd0);
            end else begin
                chk("r_data_oor", o_r_data, 32'd0);
                chk("r_resp_oor", 32'(o_r_resp), 32'd2);
            end
            @(posedge clk);
            if (rdy) beat++;
        end
        chk("r_beats", 32'(beat), 32'(len + 1));
        #1 i_r_ready = 1'b0;
        @(negedge clk);
        chk("r_idle", 32'(o_r_valid), 32'd0);
        chk("ar_gap", 32'(o_ar_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic [1:0]  resp, resp2;
        int n, a, l;
        arstn = 1'b0;
        i_ar_valid = 0; i_ar_addr = 0; i_ar_len = 0; i_r_ready = 0;
        i_aw_valid = 0; i_aw_addr = 0; i_aw_len = 0;
        i_w_valid = 0; i_w_data = 0; i_w_strb = 0; i_w_last = 0;
        i_b_ready = 0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        chk("rst_r_valid", 32'(o_r_valid), 32'd0);
        chk("rst_r_last", 32'(o_r_last), 32'd0);
        chk("rst_r_data", o_r_data, 32'd0);
        chk("rst_r_resp", 32'(o_r_resp), 32'd0);
        chk("rst_w_ready", 32'(o_w_ready), 32'd0);
        chk("rst_b_valid", 32'(o_b_valid), 32'd0);
        chk("rst_ar_ready", 32'(o_ar_ready), 32'd1);
        chk("rst_aw_ready", 32'(o_aw_ready), 32'd1);

        dq.delete(); sq.delete();
        for (int i = 0; i < 128; i++) begin
            dq.push_back($urandom); sq.push_back(4'hf);
        end
        wr(0, 127, dq, sq, resp);
        dq.delete(); sq.delete();
        for (int i = 0; i < 2; i++) begin
            dq.push_back($urandom); sq.push_back(4'hf);
        end
        wr((DEPTH - 2) * 4, 1, dq, sq, resp);

        dq.delete(); sq.delete();
        dq.push_back(32'h11); dq.push_back(32'h22);
        dq.push_back(32'h33); dq.push_back(32'h44);
        for (int i = 0; i < 4; i++) sq.push_back(4'hf);
        wr(32'h10, 3, dq, sq, resp);
        rd(32'h10, 3, 0);

        dq.delete(); sq.delete();
        dq.push_back(32'h0); sq.push_back(4'hf);
        wr(32'h20, 0, dq, sq, resp);
        dq.delete(); sq.delete();
        dq.push_back(32'hAABBCCDD); sq.push_back(4'b0101);
        wr(32'h20, 0, dq, sq, resp);
        rd(32'h20, 0, 0);
        @(negedge clk);
        i_ar_valid = 1'b1; i_ar_addr = 32'h20; i_ar_len = 8'd0;
        @(posedge clk); #1 i_ar_valid = 1'b0;
        chk("strb_merge", o_r_data, 32'h00BB00DD);
        @(negedge clk); i_r_ready = 1'b1;
        @(posedge clk); #1 i_r_ready = 1'b0;

        rd(32'h10, 3, 1);
        rd((DEPTH - 2) * 4, 3, 0);

        dq.delete(); sq.delete();
        dq.push_back($urandom); dq.push_back($urandom);
        sq.push_back(4'hf); sq.push_back(4'hf);
        wr(32'h40, 3, dq, sq, resp);
        chk("early_last_resp", 32'(resp), 32'd2);
        @(negedge clk);
        chk("early_last_idle", 32'(o_aw_ready), 32'd1);
        rd(32'h40, 1, 0);

        dq.delete(); sq.delete();
        for (int i = 0; i < 3; i++) begin
            dq.push_back($urandom); sq.push_back(4'hf);
        end
        wr(32'h60, 1, dq, sq, resp);
        rd(32'h60, 2, 0);

        dq.delete(); sq.delete();
        dq.push_back($urandom); dq.push_back($urandom);
        sq.push_back(4'hf); sq.push_back(4'hf);
        wr((DEPTH - 1) * 4, 1, dq, sq, resp);
        chk("oor_wr_resp", 32'(resp), 32'd2);
        rd((DEPTH - 1) * 4, 0, 0);

        @(negedge clk);
        i_aw_valid = 1'b1; i_aw_addr = 32'h100; i_aw_len = 8'd3;
        n = 0;
        while (!o_aw_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 i_aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            i_w_valid = 1'b1; i_w_data = $urandom; i_w_strb = 4'hf;
            n = 0;
            while (!o_w_ready && n < 100) begin @(negedge clk); n++; end
            chk("mid_w_ready", 32'(o_w_ready), 32'd1);
            @(posedge clk);
            mdl[64 + b] = i_w_data; known[64 + b] = 1'b1;
            #1 i_w_valid = 1'b0;
        end
        @(negedge clk); arstn = 1'b0;
        @(posedge clk); #1 arstn = 1'b1;
        chk("mid_rst_b_valid", 32'(o_b_valid), 32'd0);
        chk("mid_rst_aw_ready", 32'(o_aw_ready), 32'd1);
        chk("mid_rst_w_ready", 32'(o_w_ready), 32'd0);
        rd(32'h100, 1, 0);

        for (int it = 0; it < 16; it++) begin
            a = $urandom_range(0, 100);
            l = $urandom_range(0, 15);
            dq.delete(); sq.delete();
            for (int i = 0; i <= l; i++) begin
                dq.push_back($urandom);
                sq.push_back(4'($urandom_range(0, 15)));
            end
            wr(a * 4, l, dq, sq, resp);
            rd(a * 4, l, 2);
        end

        dq.delete(); sq.delete();
        for (int i = 0; i < 8; i++) begin
            dq.push_back($urandom); sq.push_back(4'hf);
        end
        fork
            wr(32'h0, 7, dq, sq, resp2);
            rd(32'h100, 7, 2);
        join
        rd(32'h0, 7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
